act_tensor_writer: RTL and testbench
====================================

Name: act_tensor_writer

Overview:
- Consumer end of the STA output pixel stream: takes the per-pixel int8 stream (valid/value/row/col, or valid/value/index in bypass) and writes it into the activation tensor RAM in channel-last layout.
- Packs adjacent bytes into 32-bit words with byte enables, buffers them in a small FIFO, and drains to the RAM under a ready handshake.
- Raises a done pulse once a layer's stream has been fully committed.

Parameters:
- MAX_N, 64, max feature-map dimension.
- N_BITS, $clog2(MAX_N), row/col width.
- MAX_NUM_CH, 64, max channels per layer.
- CH_BITS, $clog2(MAX_NUM_CH+1), channel-count width.
- BYPASS_IDX_BITS, 6, bypass index width.
- ADDR_W, 16, byte-address width of the tensor RAM.
- FIFO_DEPTH, 4, word-FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latches cfg_*, enters ACTIVE.
- cfg_base_addr  in  ADDR_W  tensor base byte address.
- cfg_img_w  in  N_BITS+1  output width in pixels.
- cfg_num_ch  in  CH_BITS  channels per pixel.
- cfg_ch_idx  in  CH_BITS  channel this pass writes.
- cfg_bypass  in  1  1 means index addressing (fully connected).
- flush  in  1  pulse: upstream stream finished.
- in_valid  in  1  pixel valid.
- in_val  in  8  int8 pixel.
- in_row  in  N_BITS  pixel row.
- in_col  in  N_BITS  pixel col.
- in_index  in  BYPASS_IDX_BITS  bypass index.
- mem_we  out  1  write request.
- mem_ready  in  1  RAM accepts when mem_we&&mem_ready.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  write data; lane k is bits [8k+7:8k].
- mem_be  out  4  byte enables.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: pixel dropped because the FIFO was full.

Behaviour:
- Reset:
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - busy=0, done=0, overflow=0.
  - Coalescer empty; FIFO empty.
  - Reset mid-operation discards all pending data without a write.
- FSM states:
  - IDLE: start goes to ACTIVE. in_valid and flush are ignored in IDLE.
  - ACTIVE: flush goes to DRAIN.
  - DRAIN: goes to DONE when the pipeline stage, coalescer and FIFO are all empty and no write is outstanding.
  - DONE: asserts done for one cycle, then returns to IDLE.
- start while not IDLE is ignored.
- Stage 1, registered, 1 cycle, byte address:
  - Normal mode: byte_addr = cfg_base_addr + (in_row*cfg_img_w + in_col)*cfg_num_ch + cfg_ch_idx.
  - Bypass mode: byte_addr = cfg_base_addr + in_index.
  - Computed at full width, truncated mod 2^ADDR_W (address wraps).
  - word = byte_addr[ADDR_W-1:2]; lane = byte_addr[1:0].
- Stage 2, coalescer (one word register with a 4-bit mask):
  - Empty: load word, set lane bit, write data into that lane.
  - Same word: merge the byte and OR the mask. A repeat lane overwrites its data (last wins).
  - Different word: push the held entry to the FIFO, then load the new byte.
  - mask==4'hF: push in the same cycle the mask completes.
  - Entering DRAIN: push a non-empty coalescer immediately.
- FIFO:
  - Head drives mem_addr/mem_wdata/mem_be; mem_we = !empty.
  - Pop on mem_we&&mem_ready.
  - Push and pop in the same cycle is allowed when full.
  - Outputs must hold stable while mem_we && !mem_ready.
- Overflow:
  - Condition: a push is required while the FIFO is full and there is no pop.
  - The held coalescer word is dropped, the new byte loads, and overflow sets.
  - overflow clears only on reset or start.
- Latency: an isolated pixel followed by flush, with mem_ready=1, reaches mem_we ≤3 cycles after in_valid.
- Upstream has no backpressure: in_valid is sampled every ACTIVE cycle.
- flush and in_valid in the same cycle: that pixel is still written before done.
- A new start is accepted on the cycle after done.

Test Plan:
- Normal mode contiguous channels:
  - Stimulus: base=0x100, img_w=4, num_ch=4. Four passes, ch_idx=0..3, each writing pixel (1,2) with vals 0x11,0x22,0x33,0x44, each pass then flush.
  - Response: four writes to word 0x46 with be=1,2,4,8 in turn; done after each.
- Coalescing:
  - Stimulus: bypass, base=0, indices 0..7, vals 1..8, back-to-back, then flush.
  - Response: exactly two writes. Addr 0, data 0x04030201, be=F. Addr 1, data 0x08070605, be=F.
- Backpressure and overflow:
  - Stimulus: mem_ready=0; bypass indices 0,4,8,12,16,20 (one per word).
  - Response: FIFO fills at 4 entries. The fifth push drops a word and overflow=1. mem_* stays stable throughout. After mem_ready=1, four writes then the held word are committed.
- Flush edge:
  - Stimulus: flush in the same cycle as the last in_valid (index 5, val 0x7F).
  - Response: write addr 1, be=4'b0010, data lane1=0x7F; done follows it.
- Wrap:
  - Stimulus: base=0xFFFE, bypass index 3.
  - Response: byte_addr=0x0001, so mem_addr=0, be=4'b0010.
- Reset mid-DRAIN:
  - Stimulus: reset with 2 FIFO entries pending.
  - Response: next cycle mem_we=0, busy=0, done never pulses, no further writes.

Source files
------------

// File: rtl/act_tensor_writer.sv
// Writes the int8 output pixel stream into the channel-last activation tensor RAM:
// address stage, 32-bit word coalescer with byte enables, small word FIFO towards the RAM port.
module act_tensor_writer #(
   parameter int MAX_N           = 64,
   parameter int N_BITS          = $clog2(MAX_N),
   parameter int MAX_NUM_CH      = 64,
   parameter int CH_BITS         = $clog2(MAX_NUM_CH + 1),
   parameter int BYPASS_IDX_BITS = 6,
   parameter int ADDR_W          = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          cfg_base_addr,
   input  logic [N_BITS:0]            cfg_img_w,
   input  logic [CH_BITS-1:0]         cfg_num_ch,
   input  logic [CH_BITS-1:0]         cfg_ch_idx,
   input  logic                       cfg_bypass,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [7:0]                 in_val,
   input  logic [N_BITS-1:0]          in_row,
   input  logic [N_BITS-1:0]          in_col,
   input  logic [BYPASS_IDX_BITS-1:0] in_index,
   output logic                       mem_we,
   input  logic                       mem_ready,
   output logic [ADDR_W-3:0]          mem_addr,
   output logic [31:0]                mem_wdata,
   output logic [3:0]                 mem_be,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow
);

   localparam int WORD_W = ADDR_W - 2;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0]  base_r;
   logic [N_BITS:0]    img_w_r;
   logic [CH_BITS-1:0] num_ch_r, ch_idx_r;
   logic               bypass_r;

   // Arithmetic mod 2^ADDR_W throughout, which equals the wide result truncated.
   function automatic logic [ADDR_W-1:0] pixel_addr(
      input logic [ADDR_W-1:0] base, input logic [N_BITS:0] img_w,
      input logic [CH_BITS-1:0] num_ch, input logic [CH_BITS-1:0] ch_idx,
      input logic bypass, input logic [N_BITS-1:0] row, input logic [N_BITS-1:0] col,
      input logic [BYPASS_IDX_BITS-1:0] idx);
      logic [ADDR_W-1:0] lin;
      if (bypass)
         return base + ADDR_W'(idx);
      lin = ADDR_W'(row) * ADDR_W'(img_w) + ADDR_W'(col);
      return base + lin * ADDR_W'(num_ch) + ADDR_W'(ch_idx);
   endfunction

   logic              start_acc, capture;
   logic [ADDR_W-1:0] byte_addr;

   assign start_acc = start && (state == S_IDLE);
   assign capture   = in_valid && (state == S_ACTIVE);
   assign byte_addr = pixel_addr(base_r, img_w_r, num_ch_r, ch_idx_r, bypass_r,
                                 in_row, in_col, in_index);

   always_ff @(posedge clk) begin
      if (start_acc) begin
         base_r   <= cfg_base_addr;
         img_w_r  <= cfg_img_w;
         num_ch_r <= cfg_num_ch;
         ch_idx_r <= cfg_ch_idx;
         bypass_r <= cfg_bypass;
      end
   end

   // ---- stage p0: byte address ----
   logic                    vld_p0;
   logic [WORD_W-1:0]       word_p0;
   logic [1:0]              lane_p0;
   logic signed [7:0]       val_p0;

   always_ff @(posedge clk) begin
      if (reset) vld_p0 <= 1'b0;
      else       vld_p0 <= capture;
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         word_p0 <= byte_addr[ADDR_W-1:2];
         lane_p0 <= byte_addr[1:0];
         val_p0  <= $signed(in_val);
      end
   end

   // ---- stage p1: word coalescer ----
   logic              vld_p1, vld_p1_nxt;
   logic [WORD_W-1:0] word_p1, word_p1_nxt;
   logic [3:0]        mask_p1, mask_p1_nxt, m_mask;
   logic [31:0]       data_p1, data_p1_nxt, m_data;
   logic              same, draining, push, pop, can_push, ovf_set;
   logic [WORD_W-1:0] push_word;
   logic [3:0]        push_mask;
   logic [31:0]       push_data;
   logic              fifo_empty, fifo_full;

   assign pop      = mem_we && mem_ready;
   assign can_push = !fifo_full || pop;
   assign draining = (state == S_DRAIN);

   always_comb begin
      vld_p1_nxt  = vld_p1;
      word_p1_nxt = word_p1;
      mask_p1_nxt = mask_p1;
      data_p1_nxt = data_p1;
      push        = 1'b0;
      push_word   = word_p1;
      push_mask   = mask_p1;
      push_data   = data_p1;
      ovf_set     = 1'b0;
      same        = vld_p1 && (word_p1 == word_p0);
      m_mask      = (same ? mask_p1 : 4'h0) | (4'b0001 << lane_p0);
      m_data      = same ? data_p1 : 32'h0;
      m_data[8*lane_p0 +: 8] = val_p0;
      if (vld_p0) begin
         if (vld_p1 && !same) begin
            // A different word evicts the held one; with no room it is lost.
            push        = can_push;
            ovf_set     = !can_push;
            word_p1_nxt = word_p0;
            mask_p1_nxt = m_mask;
            data_p1_nxt = m_data;
         end else begin
            vld_p1_nxt  = 1'b1;
            word_p1_nxt = word_p0;
            mask_p1_nxt = m_mask;
            data_p1_nxt = m_data;
            if (m_mask == 4'hF || draining) begin
               push_word = word_p0;
               push_mask = m_mask;
               push_data = m_data;
               if (can_push) begin
                  push       = 1'b1;
                  vld_p1_nxt = 1'b0;
               end else if (!draining) begin
                  ovf_set    = 1'b1;
                  vld_p1_nxt = 1'b0;
               end
            end
         end
      end else if (vld_p1 && draining && can_push) begin
         push       = 1'b1;
         vld_p1_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= vld_p1_nxt;
   end

   always_ff @(posedge clk) begin
      word_p1 <= word_p1_nxt;
      mask_p1 <= mask_p1_nxt;
      data_p1 <= data_p1_nxt;
   end

   // ---- word FIFO towards the RAM ----
   logic [WORD_W-1:0] fifo_word [FIFO_DEPTH];
   logic [31:0]       fifo_data [FIFO_DEPTH];
   logic [3:0]        fifo_be   [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}});

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_word[wr_ptr[PTR_W-1:0]] <= push_word;
         fifo_data[wr_ptr[PTR_W-1:0]] <= push_data;
         fifo_be[wr_ptr[PTR_W-1:0]]   <= push_mask;
      end
   end

   assign mem_we    = !fifo_empty;
   assign mem_addr  = mem_we ? fifo_word[rd_ptr[PTR_W-1:0]] : '0;
   assign mem_wdata = mem_we ? fifo_data[rd_ptr[PTR_W-1:0]] : '0;
   assign mem_be    = mem_we ? fifo_be[rd_ptr[PTR_W-1:0]]   : '0;

   // ---- control ----
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_ACTIVE;
         S_ACTIVE: if (flush) state_nxt = S_DRAIN;
         S_DRAIN:  if (!vld_p0 && !vld_p1 && fifo_empty) state_nxt = S_DONE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset)          overflow <= 1'b0;
      else if (start_acc) overflow <= 1'b0;
      else if (ovf_set)   overflow <= 1'b1;
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_act_tensor_writer.sv
// Bench for act_tensor_writer: directed layer scenarios with literal expectations plus
// randomized layers, all checked every cycle against a queue-based reference model.
module tb_act_tensor_writer;

   localparam int N_BITS  = 6;
   localparam int CH_BITS = 7;
   localparam int ADDR_W  = 16;

   logic        clk = 1'b0;
   logic        reset, start, cfg_bypass, flush, in_valid, mem_ready;
   logic [15:0] cfg_base_addr;
   logic [6:0]  cfg_img_w, cfg_num_ch, cfg_ch_idx;
   logic [7:0]  in_val;
   logic [5:0]  in_row, in_col, in_index;
   logic        mem_we, busy, done, overflow;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   always #5 clk = ~clk;

   act_tensor_writer dut (
      .clk(clk), .reset(reset), .start(start), .cfg_base_addr(cfg_base_addr),
      .cfg_img_w(cfg_img_w), .cfg_num_ch(cfg_num_ch), .cfg_ch_idx(cfg_ch_idx),
      .cfg_bypass(cfg_bypass), .flush(flush), .in_valid(in_valid), .in_val(in_val),
      .in_row(in_row), .in_col(in_col), .in_index(in_index), .mem_we(mem_we),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .busy(busy), .done(done), .overflow(overflow)
   );

   typedef struct {int word; bit [31:0] data; bit [3:0] be;} wr_t;

   int  n_chk = 0, n_fail = 0;
   bit  chk_en = 0;
   wr_t wlog[$];
   int  done_cnt = 0;

   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   int        m_st;                 // 0 idle, 1 streaming, 2 draining, 3 done
   int        m_base, m_w, m_nch, m_ch;
   bit        m_byp;
   bit        m_pv;
   int        m_pa;
   bit [7:0]  m_pval;
   bit        m_cv;
   int        m_cw;
   bit [3:0]  m_cm;
   bit [7:0]  m_cb[4];
   bit        m_ovf;
   wr_t       mq[$];

   function automatic bit [31:0] held_data();
      return {m_cb[3], m_cb[2], m_cb[1], m_cb[0]};
   endfunction

   function automatic void model_step();
      bit pop, can_push, drain, do_push, diff, n_pv;
      int nst, n_pa, pw, pl;
      wr_t pe;
      if (reset) begin
         m_st = 0; m_pv = 0; m_cv = 0; m_ovf = 0; mq.delete();
         return;
      end
      pop      = (mq.size() > 0) && mem_ready;
      can_push = (mq.size() < 4) || pop;
      drain    = (m_st == 2);
      do_push  = 0;
      pe       = '{0, 32'h0, 4'h0};
      nst      = m_st;
      case (m_st)
         0: if (start) nst = 1;
         1: if (flush) nst = 2;
         2: if (!m_pv && !m_cv && mq.size() == 0) nst = 3;
         default: nst = 0;
      endcase
      n_pv = (m_st == 1) && in_valid;
      n_pa = 0;
      if (n_pv) begin
         if (m_byp) n_pa = (m_base + int'(in_index)) % 65536;
         else       n_pa = ((int'(in_row) * m_w + int'(in_col)) * m_nch + m_ch + m_base) % 65536;
      end
      if (m_pv) begin
         pw   = m_pa / 4;
         pl   = m_pa % 4;
         diff = m_cv && (m_cw != pw);
         if (diff) begin
            if (can_push) begin do_push = 1; pe = '{m_cw, held_data(), m_cm}; end
            else m_ovf = 1;
         end
         if (diff || !m_cv) begin
            m_cw = pw; m_cm = 4'h0;
            foreach (m_cb[i]) m_cb[i] = 8'h0;
         end
         m_cv = 1;
         m_cb[pl] = m_pval;
         m_cm = m_cm | 4'(1 << pl);
         if (!diff && (m_cm == 4'hF || drain)) begin
            if (can_push) begin
               do_push = 1; pe = '{m_cw, held_data(), m_cm}; m_cv = 0;
            end else if (!drain) begin
               m_ovf = 1; m_cv = 0;
            end
         end
      end else if (m_cv && drain && can_push) begin
         do_push = 1; pe = '{m_cw, held_data(), m_cm}; m_cv = 0;
      end
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(pe);
      if (m_st == 0 && start) begin
         m_base = int'(cfg_base_addr); m_w = int'(cfg_img_w);
         m_nch = int'(cfg_num_ch); m_ch = int'(cfg_ch_idx); m_byp = cfg_bypass;
         m_ovf = 0;
      end
      m_pv = n_pv; m_pa = n_pa; m_pval = in_val; m_st = nst;
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("mem_we", 64'(mem_we), 64'(mq.size() > 0));
         if (mq.size() > 0) begin
            check("mem_addr", 64'(mem_addr), 64'(mq[0].word));
            check("mem_wdata", 64'(mem_wdata), 64'(mq[0].data));
            check("mem_be", 64'(mem_be), 64'(mq[0].be));
         end else begin
            check("mem_addr_idle", 64'(mem_addr), 64'(0));
            check("mem_wdata_idle", 64'(mem_wdata), 64'(0));
            check("mem_be_idle", 64'(mem_be), 64'(0));
         end
         check("busy", 64'(busy), 64'(m_st != 0));
         check("done", 64'(done), 64'(m_st == 3));
         check("overflow", 64'(overflow), 64'(m_ovf));
         if (mem_we && mem_ready) wlog.push_back('{int'(mem_addr), mem_wdata, mem_be});
         if (done) done_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start(input int base, input int w, input int nch, input int ch, input bit byp);
      cfg_base_addr = 16'(base); cfg_img_w = 7'(w); cfg_num_ch = 7'(nch);
      cfg_ch_idx = 7'(ch); cfg_bypass = byp;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic pix(input int val, input int row, input int col, input int idx, input bit fl);
      in_valid = 1'b1; in_val = 8'(val); in_row = 6'(row); in_col = 6'(col);
      in_index = 6'(idx); flush = fl;
      cyc();
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic wait_done(input int lim, input bit rnd_ready);
      bit seen = 0;
      for (int i = 0; i < lim && !seen; i++) begin
         if (done) seen = 1;
         else begin
            if (rnd_ready) mem_ready = ($urandom_range(0, 9) < 7);
            cyc();
         end
      end
      check("done_seen", 64'(seen), 64'(1));
      if (seen) cyc();
   endtask

   task automatic check_wr(input string nm, input int i, input int word, input int data, input int be);
      if (wlog.size() > i) begin
         check({nm, "_addr"}, 64'(wlog[i].word), 64'(word));
         check({nm, "_data"}, 64'(wlog[i].data), 64'(unsigned'(data)));
         check({nm, "_be"}, 64'(wlog[i].be), 64'(be));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random scenarios ----------------
   initial begin
      int row, col, idx, npix, nch;
      bit same_flush;
      reset = 1'b1; start = 0; flush = 0; in_valid = 0; mem_ready = 1;
      cfg_base_addr = 0; cfg_img_w = 0; cfg_num_ch = 0; cfg_ch_idx = 0; cfg_bypass = 0;
      in_val = 0; in_row = 0; in_col = 0; in_index = 0;
      cyc(); cyc();
      chk_en = 1;
      check("rst_mem_we", 64'(mem_we), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_overflow", 64'(overflow), 64'(0));
      reset = 1'b0;
      cyc();

      // Normal mode, four channel passes into the same pixel word.
      wlog.delete(); done_cnt = 0;
      for (int ch = 0; ch < 4; ch++) begin
         do_start(16'h100, 4, 4, ch, 0);
         pix(8'h11 * (ch + 1), 1, 2, 0, 0);
         flush = 1'b1; cyc(); flush = 1'b0;
         wait_done(30, 0);
      end
      check("t1_count", 64'(wlog.size()), 64'(4));
      check("t1_done", 64'(done_cnt), 64'(4));
      for (int ch = 0; ch < 4; ch++)
         check_wr("t1", ch, 16'h46, (8'h11 * (ch + 1)) << (8 * ch), 1 << ch);

      // Coalescing of eight consecutive bypass bytes.
      wlog.delete();
      do_start(0, 1, 1, 0, 1);
      for (int k = 0; k < 8; k++) pix(k + 1, 0, 0, k, 0);
      flush = 1'b1; cyc(); flush = 1'b0;
      wait_done(30, 0);
      check("t2_count", 64'(wlog.size()), 64'(2));
      check_wr("t2w0", 0, 0, 32'h04030201, 4'hF);
      check_wr("t2w1", 1, 1, 32'h08070605, 4'hF);

      // Backpressure fills the FIFO and the fifth eviction is dropped.
      wlog.delete();
      mem_ready = 1'b0;
      do_start(0, 1, 1, 0, 1);
      for (int k = 0; k < 6; k++) pix(8'hA0 + k, 0, 0, 4 * k, 0);
      cyc(); cyc(); cyc();
      check("t3_overflow", 64'(overflow), 64'(1));
      check("t3_stall_we", 64'(mem_we), 64'(1));
      check("t3_stall_addr", 64'(mem_addr), 64'(0));
      mem_ready = 1'b1; flush = 1'b1; cyc(); flush = 1'b0;
      wait_done(40, 0);
      check("t3_count", 64'(wlog.size()), 64'(5));
      check_wr("t3w0", 0, 0, 8'hA0, 1);
      check_wr("t3w1", 1, 1, 8'hA1, 1);
      check_wr("t3w2", 2, 2, 8'hA2, 1);
      check_wr("t3w3", 3, 3, 8'hA3, 1);
      check_wr("t3w5", 4, 5, 8'hA5, 1);
      check("t3_sticky", 64'(overflow), 64'(1));

      // Flush coinciding with the last pixel; start clears overflow.
      wlog.delete();
      do_start(0, 1, 1, 0, 1);
      check("t4_ovf_clr", 64'(overflow), 64'(0));
      pix(8'h7F, 0, 0, 5, 1);
      wait_done(30, 0);
      check("t4_count", 64'(wlog.size()), 64'(1));
      check_wr("t4", 0, 1, 32'h00007F00, 4'b0010);

      // Address wrap.
      wlog.delete();
      do_start(16'hFFFE, 1, 1, 0, 1);
      pix(8'h5A, 0, 0, 3, 1);
      wait_done(30, 0);
      check("t5_count", 64'(wlog.size()), 64'(1));
      check_wr("t5", 0, 0, 32'h00005A00, 4'b0010);

      // Reset while draining with two words pending.
      mem_ready = 1'b0;
      do_start(0, 1, 1, 0, 1);
      pix(8'h01, 0, 0, 0, 0);
      pix(8'h02, 0, 0, 4, 0);
      flush = 1'b1; cyc(); flush = 1'b0;
      cyc(); cyc(); cyc();
      check("t6_pending", 64'(mem_we), 64'(1));
      reset = 1'b1; cyc(); reset = 1'b0;
      check("t6_we", 64'(mem_we), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      wlog.delete(); done_cnt = 0;
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      check("t6_no_writes", 64'(wlog.size()), 64'(0));
      check("t6_no_done", 64'(done_cnt), 64'(0));

      // Randomized layers against the model.
      for (int layer = 0; layer < 25; layer++) begin
         for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 9) < 7);
            cyc();
         end
         in_valid = 0; flush = 0;
         nch = $urandom_range(0, 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 64));
         do_start(int'($urandom_range(0, 65535)), int'($urandom_range(1, 64)), nch,
                  int'($urandom_range(0, nch - 1)), 1'($urandom_range(0, 1)));
         npix = $urandom_range(4, 40);
         row = $urandom_range(0, 63); col = $urandom_range(0, 63); idx = $urandom_range(0, 63);
         same_flush = 1'($urandom_range(0, 1));
         for (int p = 0; p < npix; p++) begin
            in_valid = ($urandom_range(0, 9) < 7) || (p == npix - 1);
            in_val = 8'($urandom_range(0, 255));
            in_row = 6'(row); in_col = 6'(col); in_index = 6'(idx);
            start = ($urandom_range(0, 19) == 0);
            flush = (p == npix - 1) && same_flush;
            mem_ready = ($urandom_range(0, 9) < 7);
            cyc();
            if (in_valid) begin
               if ($urandom_range(0, 3) != 0) begin
                  col = (col + 1) % 64;
                  if (col == 0) row = (row + 1) % 64;
                  idx = (idx + 1) % 64;
               end else begin
                  row = $urandom_range(0, 63); col = $urandom_range(0, 63);
                  idx = $urandom_range(0, 63);
               end
            end
         end
         in_valid = 0; start = 0; flush = 0;
         if (!same_flush) begin
            flush = 1'b1; cyc(); flush = 1'b0;
         end
         wait_done(400, 1);
      end
      mem_ready = 1'b1;
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
